// File: rtl/tri_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tri_dispatch_pkg
// Brief   : Shared types for the triangle dispatcher: operand record and FSM states.
// Revision: 1.0 - initial release
// ============================================================================
package tri_dispatch_pkg;

    localparam int c_LG_TRI_Q_SZ = 2;

    // Field order follows the fragment_generator operand ports, MSB first.
    typedef struct packed {
        logic [31:0] ymin;
        logic [31:0] ymax;
        logic [31:0] xmin;
        logic [31:0] xmax;
        logic [31:0] l0_dx;
        logic [31:0] l0_dy;
        logic [31:0] l1_dx;
        logic [31:0] l1_dy;
        logic [31:0] l2_dx;
        logic [31:0] l2_dy;
        logic [31:0] w0_00;
        logic [31:0] w1_00;
        logic [31:0] w2_00;
    } triangle_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    // Bounding-box coordinates are two's complement.
    function automatic logic is_degenerate(input triangle_t t);
        return ($signed(t.xmin) > $signed(t.xmax)) ||
               ($signed(t.ymin) > $signed(t.ymax));
    endfunction

endpackage
`default_nettype wire

// File: rtl/tri_dispatch_queue.sv
`default_nettype none
// ============================================================================
// Module  : tri_queue
// Brief   : Circular triangle FIFO with wrap-bit pointers and head read port.
// Revision: 1.0 - initial release
// ============================================================================
module tri_queue
    import tri_dispatch_pkg::*;
#(
    parameter int LG_DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  logic      i_pop,
    input  triangle_t i_data,
    output triangle_t o_head,
    output logic      o_full,
    output logic      o_empty
);

    localparam int c_DEPTH = 1 << LG_DEPTH;

    triangle_t             r_mem [c_DEPTH];
    logic [LG_DEPTH:0]     r_head;
    logic [LG_DEPTH:0]     r_tail;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign o_full    = (r_head[LG_DEPTH-1:0] == r_tail[LG_DEPTH-1:0]) &&
                       (r_head[LG_DEPTH] != r_tail[LG_DEPTH]);
    assign o_empty   = (r_head == r_tail);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_head[LG_DEPTH-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_do_push) r_tail <= r_tail + (LG_DEPTH+1)'(1);
            if (w_do_pop)  r_head <= r_head + (LG_DEPTH+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_tail[LG_DEPTH-1:0]] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/tri_dispatch.sv
`default_nettype none
// ============================================================================
// Module  : tri_dispatch
// Brief   : Queues set-up triangles and sequences them through fragment_generator.
// Revision: 1.0 - initial release
// ============================================================================
module tri_dispatch
    import tri_dispatch_pkg::*;
#(
    parameter int LG_TRI_Q_SZ  = c_LG_TRI_Q_SZ,
    parameter int DRAIN_CYCLES = 8,
    parameter int TIMEOUT_CYC  = 1048576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tri_val,
    input  triangle_t   tri_in,
    output logic        tri_rdy,
    output logic        gen_start,
    output logic [31:0] gen_ymin,
    output logic [31:0] gen_ymax,
    output logic [31:0] gen_xmin,
    output logic [31:0] gen_xmax,
    output logic [31:0] gen_l0_dx,
    output logic [31:0] gen_l0_dy,
    output logic [31:0] gen_l1_dx,
    output logic [31:0] gen_l1_dy,
    output logic [31:0] gen_l2_dx,
    output logic [31:0] gen_l2_dy,
    output logic [31:0] gen_w0_00,
    output logic [31:0] gen_w1_00,
    output logic [31:0] gen_w2_00,
    input  logic        gen_done,
    input  logic        frag_val,
    input  logic        pop_frag,
    output logic        busy,
    output logic [31:0] tris_done,
    output logic [31:0] tris_rejected,
    output logic [31:0] frag_count,
    output logic        timeout
);

    localparam int                  c_DRAIN_W    = $clog2(DRAIN_CYCLES + 1);
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_LAST = c_DRAIN_W'(DRAIN_CYCLES);
    localparam logic [31:0]         c_TIMEOUT    = 32'(TIMEOUT_CYC);
    localparam logic [31:0]         c_TIMEOUT_M1 = 32'(TIMEOUT_CYC - 1);

    state_t                 r_state;
    state_t                 w_next;
    triangle_t              r_ops;
    triangle_t              w_head;
    logic                   w_q_full;
    logic                   w_q_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_head_degen;
    logic                   w_reject;
    logic                   w_latch;
    logic                   w_retire;
    logic                   w_drain_ok;
    logic                   w_in_flight;
    logic [31:0]            r_run_cnt;
    logic [c_DRAIN_W-1:0]   r_drain_cnt;
    logic [31:0]            r_tris_done;
    logic [31:0]            r_tris_rej;
    logic [31:0]            r_frag_cnt;
    logic                   r_timeout;

    assign tri_rdy      = !rst && !w_q_full;
    assign w_push       = tri_val && tri_rdy;
    // The head stays queued until retire, so queue occupancy includes the in-flight triangle.
    assign w_pop        = w_reject || w_retire;
    assign w_head_degen = is_degenerate(w_head);
    assign w_drain_ok   = (r_drain_cnt == c_DRAIN_LAST);
    assign w_in_flight  = (r_state == ST_RUN) || (r_state == ST_DRAIN);

    tri_queue #(
        .LG_DEPTH (LG_TRI_Q_SZ)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (tri_in),
        .o_head  (w_head),
        .o_full  (w_q_full),
        .o_empty (w_q_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (!w_q_empty && !w_head_degen) w_next = ST_LAUNCH;
            ST_LAUNCH: w_next = ST_RUN;
            ST_RUN:    if (gen_done) w_next = ST_DRAIN;
            ST_DRAIN:  if (w_drain_ok && !frag_val) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        gen_start = 1'b0;
        w_reject  = 1'b0;
        w_latch   = 1'b0;
        w_retire  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_q_empty) begin
                    w_reject = w_head_degen;
                    w_latch  = !w_head_degen;
                end
            end
            ST_LAUNCH: gen_start = 1'b1;
            ST_DRAIN:  w_retire  = w_drain_ok && !frag_val;
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ops       <= '0;
            r_run_cnt   <= '0;
            r_drain_cnt <= '0;
            r_tris_done <= '0;
            r_tris_rej  <= '0;
            r_frag_cnt  <= '0;
            r_timeout   <= 1'b0;
        end else begin
            if (w_latch) begin
                r_ops      <= w_head;
                r_frag_cnt <= '0;
            end else if (w_in_flight && pop_frag) begin
                r_frag_cnt <= r_frag_cnt + 32'd1;
            end

            // Run counter saturates so the sticky timeout cannot re-arm on wrap.
            if (r_state == ST_LAUNCH) begin
                r_run_cnt <= '0;
            end else if (r_state == ST_RUN && r_run_cnt != c_TIMEOUT) begin
                r_run_cnt <= r_run_cnt + 32'd1;
            end
            if (r_state == ST_RUN && r_run_cnt == c_TIMEOUT_M1) r_timeout <= 1'b1;

            if (r_state == ST_RUN && gen_done) begin
                r_drain_cnt <= '0;
            end else if (r_state == ST_DRAIN && !w_drain_ok) begin
                r_drain_cnt <= r_drain_cnt + c_DRAIN_W'(1);
            end

            if (w_reject) r_tris_rej  <= r_tris_rej + 32'd1;
            if (w_retire) r_tris_done <= r_tris_done + 32'd1;
        end
    end

    assign busy          = (r_state != ST_IDLE) || !w_q_empty;
    assign tris_done     = r_tris_done;
    assign tris_rejected = r_tris_rej;
    assign frag_count    = r_frag_cnt;
    assign timeout       = r_timeout;

    assign gen_ymin  = r_ops.ymin;
    assign gen_ymax  = r_ops.ymax;
    assign gen_xmin  = r_ops.xmin;
    assign gen_xmax  = r_ops.xmax;
    assign gen_l0_dx = r_ops.l0_dx;
    assign gen_l0_dy = r_ops.l0_dy;
    assign gen_l1_dx = r_ops.l1_dx;
    assign gen_l1_dy = r_ops.l1_dy;
    assign gen_l2_dx = r_ops.l2_dx;
    assign gen_l2_dy = r_ops.l2_dy;
    assign gen_w0_00 = r_ops.w0_00;
    assign gen_w1_00 = r_ops.w1_00;
    assign gen_w2_00 = r_ops.w2_00;

endmodule
`default_nettype wire

// File: tb/tb_tri_dispatch.sv
`default_nettype none
// ============================================================================
// Module  : tb_tri_dispatch
// Brief   : Self-checking bench for tri_dispatch: vector table plus corner sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tri_dispatch;
    import tri_dispatch_pkg::*;

    localparam int c_TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        tri_val;
    triangle_t   tri_in;
    logic        tri_rdy, gen_start, busy, timeout;
    logic        gen_done, frag_val, pop_frag;
    logic [31:0] gen_ymin, gen_ymax, gen_xmin, gen_xmax;
    logic [31:0] gen_l0_dx, gen_l0_dy, gen_l1_dx, gen_l1_dy, gen_l2_dx, gen_l2_dy;
    logic [31:0] gen_w0_00, gen_w1_00, gen_w2_00;
    logic [31:0] tris_done, tris_rejected, frag_count;
    triangle_t   w_ops;

    always #5 clk = ~clk;

    tri_dispatch #(
        .LG_TRI_Q_SZ  (2),
        .DRAIN_CYCLES (8),
        .TIMEOUT_CYC  (c_TIMEOUT)
    ) dut (
        .clk (clk), .rst (rst), .tri_val (tri_val), .tri_in (tri_in), .tri_rdy (tri_rdy),
        .gen_start (gen_start),
        .gen_ymin (gen_ymin), .gen_ymax (gen_ymax), .gen_xmin (gen_xmin), .gen_xmax (gen_xmax),
        .gen_l0_dx (gen_l0_dx), .gen_l0_dy (gen_l0_dy), .gen_l1_dx (gen_l1_dx),
        .gen_l1_dy (gen_l1_dy), .gen_l2_dx (gen_l2_dx), .gen_l2_dy (gen_l2_dy),
        .gen_w0_00 (gen_w0_00), .gen_w1_00 (gen_w1_00), .gen_w2_00 (gen_w2_00),
        .gen_done (gen_done), .frag_val (frag_val), .pop_frag (pop_frag),
        .busy (busy), .tris_done (tris_done), .tris_rejected (tris_rejected),
        .frag_count (frag_count), .timeout (timeout)
    );

    assign w_ops = {gen_ymin, gen_ymax, gen_xmin, gen_xmax, gen_l0_dx, gen_l0_dy,
                    gen_l1_dx, gen_l1_dy, gen_l2_dx, gen_l2_dy,
                    gen_w0_00, gen_w1_00, gen_w2_00};

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_starts = 0;
    int          n_unstable = 0;
    logic        snap_valid = 1'b0;
    triangle_t   snap;
    logic [31:0] launched [$];

    // Launch monitor: records launch order and flags any operand change between launches.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            snap_valid = 1'b0;
        end else if (gen_start) begin
            n_starts++;
            launched.push_back(gen_ymin);
            snap       = w_ops;
            snap_valid = 1'b1;
        end else if (snap_valid && w_ops != snap) begin
            n_unstable++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic triangle_t mk(input logic [31:0] xmin, input logic [31:0] xmax,
                                     input logic [31:0] ymin, input logic [31:0] ymax);
        triangle_t t;
        t.ymin  = ymin;          t.ymax  = ymax;
        t.xmin  = xmin;          t.xmax  = xmax;
        t.l0_dx = ymin + 32'h11; t.l0_dy = ymin + 32'h12;
        t.l1_dx = ymin + 32'h21; t.l1_dy = ymin + 32'h22;
        t.l2_dx = ymin + 32'h31; t.l2_dy = ymin + 32'h32;
        t.w0_00 = ymin + 32'h41; t.w1_00 = ymin + 32'h42;
        t.w2_00 = ymin + 32'h43;
        return t;
    endfunction

    task automatic push(input triangle_t t, input int bound);
        int n = 0;
        @(negedge clk);
        tri_val = 1'b1;
        tri_in  = t;
        while (!tri_rdy && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!tri_rdy) check("push_rdy_wait", {31'b0, tri_rdy}, 32'd1);
        @(posedge clk);
        #1 tri_val = 1'b0;
    endtask

    task automatic wait_starts(input int target, input int bound);
        int n = 0;
        while (n_starts < target && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (n_starts < target) check("start_wait", n_starts, target);
    endtask

    task automatic wait_done(input int target, input int bound);
        int n = 0;
        while (tris_done != 32'(target) && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (tris_done != 32'(target)) check("done_wait", tris_done, target);
    endtask

    task automatic finish_tri(input int npops);
        for (int i = 0; i < npops; i++) begin
            @(negedge clk);
            pop_frag = 1'b1;
            frag_val = 1'b1;
        end
        @(negedge clk);
        pop_frag = 1'b0;
        frag_val = 1'b0;
        gen_done = 1'b1;
        @(negedge clk);
        gen_done = 1'b0;
    endtask

    typedef struct {
        triangle_t t;
        bit        rej;
        int        pops;
        int        exp_done;
        int        exp_rej;
        int        exp_starts;
        int        exp_frags;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_st, base_done;
        triangle_t t;

        tbl[0] = '{mk(32'd0, 32'd7, 32'd0, 32'd3),                 1'b0, 2, 1, 0, 1, 2};
        tbl[1] = '{mk(32'd5, 32'd2, 32'd10, 32'd12),               1'b1, 0, 1, 1, 1, 2};
        tbl[2] = '{mk(32'd1, 32'd4, 32'd20, 32'd20),               1'b0, 5, 2, 1, 2, 5};
        tbl[3] = '{mk(32'd0, 32'd1, 32'd9, 32'd3),                 1'b1, 0, 2, 2, 2, 5};
        tbl[4] = '{mk(32'hFFFF_FFFD, 32'd2, 32'hFFFF_FFFF, 32'd0), 1'b0, 0, 3, 2, 3, 0};
        tbl[5] = '{mk(32'h7FFF_FFFF, 32'h8000_0000, 32'd1, 32'd2), 1'b1, 0, 3, 3, 3, 0};

        rst = 1'b1; tri_val = 1'b0; tri_in = '0;
        gen_done = 1'b0; frag_val = 1'b0; pop_frag = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tri_rdy", {31'b0, tri_rdy}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_gen_start", {31'b0, gen_start}, 32'd0);
        check("rst_tris_done", tris_done, 32'd0);
        check("rst_frag_count", frag_count, 32'd0);
        check("rst_timeout", {31'b0, timeout}, 32'd0);
        check("rst_gen_xmax", gen_xmax, 32'd0);
        rst = 1'b0;
        #1 check("post_rst_tri_rdy", {31'b0, tri_rdy}, 32'd1);

        // Vector table: valid, degenerate and signed-boundary bounding boxes.
        for (int k = 0; k < 6; k++) begin
            push(tbl[k].t, 50);
            if (tbl[k].rej) begin
                repeat (3) @(negedge clk);
            end else begin
                wait_starts(tbl[k].exp_starts, 50);
                check($sformatf("v%0d_xmin", k), gen_xmin, tbl[k].t.xmin);
                check($sformatf("v%0d_ymax", k), gen_ymax, tbl[k].t.ymax);
                check($sformatf("v%0d_l2_dy", k), gen_l2_dy, tbl[k].t.l2_dy);
                check($sformatf("v%0d_w0_00", k), gen_w0_00, tbl[k].t.w0_00);
                finish_tri(tbl[k].pops);
                wait_done(tbl[k].exp_done, 50);
            end
            @(negedge clk);
            check($sformatf("v%0d_done", k), tris_done, tbl[k].exp_done);
            check($sformatf("v%0d_rej", k), tris_rejected, tbl[k].exp_rej);
            check($sformatf("v%0d_starts", k), n_starts, tbl[k].exp_starts);
            check($sformatf("v%0d_frags", k), frag_count, tbl[k].exp_frags);
            check($sformatf("v%0d_busy", k), {31'b0, busy}, 32'd0);
        end

        // Launch latency and exact drain length.
        t = mk(32'd0, 32'd3, 32'd50, 32'd51);
        push(t, 50);
        @(negedge clk);
        check("lat_cycle1", {31'b0, gen_start}, 32'd0);
        @(negedge clk);
        check("lat_cycle2", {31'b0, gen_start}, 32'd1);
        check("lat_w2_00", gen_w2_00, t.w2_00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pop_frag = 1'b1;
        end
        @(negedge clk);
        pop_frag = 1'b0;
        gen_done = 1'b1;
        repeat (9) begin
            @(negedge clk);
            gen_done = 1'b0;
        end
        check("drain_early", tris_done, 32'd3);
        @(negedge clk);
        check("drain_retire", tris_done, 32'd4);
        check("lat_frags", frag_count, 32'd3);

        // Five back-to-back pushes into a four-entry queue.
        launched.delete();
        base_st   = n_starts;
        base_done = 4;
        for (int k = 0; k < 4; k++) push(mk(32'd0, 32'd1, 32'(100 + k), 32'd200), 10);
        check("full_tri_rdy", {31'b0, tri_rdy}, 32'd0);
        fork
            push(mk(32'd0, 32'd1, 32'd104, 32'd200), 400);
            begin
                for (int k = 0; k < 5; k++) begin
                    wait_starts(base_st + k + 1, 100);
                    finish_tri(1);
                    wait_done(base_done + k + 1, 100);
                end
            end
        join
        @(negedge clk);
        check("b2b_launches", launched.size(), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < launched.size())
                check($sformatf("b2b_order%0d", k), launched[k], 32'(100 + k));
        end
        check("b2b_done", tris_done, 32'd9);
        check("b2b_busy", {31'b0, busy}, 32'd0);

        // frag_val held high after gen_done blocks retirement.
        base_st = n_starts;
        push(mk(32'd0, 32'd2, 32'd300, 32'd301), 50);
        wait_starts(base_st + 1, 50);
        @(negedge clk);
        gen_done = 1'b1;
        frag_val = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            gen_done = 1'b0;
            frag_val = 1'b1;
            pop_frag = (i < 8);
        end
        @(negedge clk);
        check("hold_no_retire", tris_done, 32'd9);
        frag_val = 1'b0;
        pop_frag = 1'b0;
        @(negedge clk);
        check("hold_retire", tris_done, 32'd10);
        check("hold_frags", frag_count, 32'd8);

        // gen_done never arrives: sticky timeout at RUN cycle 64.
        base_st = n_starts;
        push(mk(32'd0, 32'd2, 32'd400, 32'd401), 50);
        @(negedge clk);
        @(negedge clk);
        check("to_launch", {31'b0, gen_start}, 32'd1);
        repeat (64) @(negedge clk);
        check("to_early", {31'b0, timeout}, 32'd0);
        @(negedge clk);
        check("to_set", {31'b0, timeout}, 32'd1);
        repeat (20) @(negedge clk);
        check("to_sticky", {31'b0, timeout}, 32'd1);
        check("to_no_relaunch", n_starts, base_st + 1);
        check("to_busy", {31'b0, busy}, 32'd1);

        // Reset while in RUN, then a normal launch.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_tri_rdy", {31'b0, tri_rdy}, 32'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_done", tris_done, 32'd0);
        check("mid_rst_rej", tris_rejected, 32'd0);
        check("mid_rst_frags", frag_count, 32'd0);
        check("mid_rst_timeout", {31'b0, timeout}, 32'd0);
        t = mk(32'd2, 32'd6, 32'd500, 32'd505);
        push(t, 50);
        @(negedge clk);
        @(negedge clk);
        check("rec_launch", {31'b0, gen_start}, 32'd1);
        check("rec_xmax", gen_xmax, t.xmax);
        finish_tri(2);
        wait_done(1, 50);
        @(negedge clk);
        check("rec_done", tris_done, 32'd1);
        check("rec_frags", frag_count, 32'd2);
        check("operand_stability", n_unstable, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
